comp_bist_ctrl: RTL and testbench

COMP_BIST_CTRL -- requirements
Module: comp_bist_ctrl

---
 rtl/comp_bist_ctrl_pkg.sv | 18 +
 rtl/comp_bist_ctrl_if.sv | 37 +++
 rtl/comp_bist_ctrl_model.sv | 22 ++
 rtl/comp_bist_ctrl.sv | 119 +++++++++++
 tb/tb_comp_bist_ctrl.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/comp_bist_ctrl_pkg.sv
// Shared encodings for the comparator BIST: controller states and one-hot {gt,lt,eq} results.
// Pure declarations; no latency or flow control of its own.
package comp_bist_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WAIT  = 2'd1,
      ST_CHECK = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   typedef logic [2:0] res_t;

   localparam res_t RES_GT = 3'b100;
   localparam res_t RES_LT = 3'b010;
   localparam res_t RES_EQ = 3'b001;

endpackage

// File: rtl/comp_bist_ctrl_if.sv
// Operand/result bus between the BIST controller and the comparator, plus sweep status.
// err_cnt exists only when COMP_BIST_ERRCNT_EN is defined; no flow control on this bus.
interface comp_bist_ctrl_if #(
   parameter int WIDTH = 2
);
   logic             start;
   logic [WIDTH-1:0] a_out;
   logic [WIDTH-1:0] b_out;
   logic             gt_in;
   logic             lt_in;
   logic             eq_in;
   logic             busy;
   logic             done;
   logic             pass;
   logic [WIDTH-1:0] fail_a;
   logic [WIDTH-1:0] fail_b;
`ifdef COMP_BIST_ERRCNT_EN
   logic [2*WIDTH:0] err_cnt;
`endif

   modport master (
      input  start, gt_in, lt_in, eq_in,
      output a_out, b_out, busy, done, pass, fail_a, fail_b
`ifdef COMP_BIST_ERRCNT_EN
      , err_cnt
`endif
   );

   modport slave (
      output start, gt_in, lt_in, eq_in,
      input  a_out, b_out, busy, done, pass, fail_a, fail_b
`ifdef COMP_BIST_ERRCNT_EN
      , err_cnt
`endif
   );

endinterface

// File: rtl/comp_bist_ctrl_model.sv
// Golden unsigned comparator: one-hot {gt,lt,eq} for the operands currently driven.
// Purely combinational, zero latency, no backpressure.
module comp_bist_model
   import comp_bist_pkg::*;
#(
   parameter int WIDTH = 2
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output res_t             res
);

   always_comb begin
      res = RES_EQ;
      if (a > b) begin
         res = RES_GT;
      end else if (a < b) begin
         res = RES_LT;
      end
   end

endmodule

// File: rtl/comp_bist_ctrl.sv
// Exhaustive comparator BIST: 2^(2*WIDTH) vectors, each held SETTLE_CYC cycles then checked.
// COMP_BIST_ERRCNT_EN: count all mismatches (full sweep); else stop on the first. start ignored while busy.
module comp_bist_ctrl
   import comp_bist_pkg::*;
#(
   parameter int WIDTH      = 2,
   parameter int SETTLE_CYC = 1
) (
   input logic             clk,
   input logic             rst,
   comp_bist_ctrl_if.master bus
);

   localparam int         IW     = 2 * WIDTH;
   localparam logic [3:0] SETTLE = 4'(SETTLE_CYC);
`ifdef COMP_BIST_ERRCNT_EN
   localparam bit STOP_ON_FAIL = 1'b0;
`else
   localparam bit STOP_ON_FAIL = 1'b1;
`endif

   state_t           state;
   logic [IW-1:0]    idx;
   logic [3:0]       settle;
   logic             busy;
   logic             done;
   logic             pass;
   logic [WIDTH-1:0] fail_a;
   logic [WIDTH-1:0] fail_b;
   res_t             exp_res;
   logic             mismatch;
`ifdef COMP_BIST_ERRCNT_EN
   logic [IW:0]      err_cnt;
   assign bus.err_cnt = err_cnt;
`endif

   assign bus.a_out  = idx[IW-1:WIDTH];
   assign bus.b_out  = idx[WIDTH-1:0];
   assign bus.busy   = busy;
   assign bus.done   = done;
   assign bus.pass   = pass;
   assign bus.fail_a = fail_a;
   assign bus.fail_b = fail_b;

   comp_bist_model #(.WIDTH(WIDTH)) u_model (
      .a   (idx[IW-1:WIDTH]),
      .b   (idx[WIDTH-1:0]),
      .res (exp_res)
   );

   // Zero-hot and multi-hot comparator outputs are mismatches too.
   assign mismatch = ({bus.gt_in, bus.lt_in, bus.eq_in} != exp_res);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= ST_IDLE;
         idx     <= '0;
         settle  <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
         pass    <= 1'b0;
         fail_a  <= '0;
         fail_b  <= '0;
`ifdef COMP_BIST_ERRCNT_EN
         err_cnt <= '0;
`endif
      end else begin
         case (state)
            ST_IDLE, ST_DONE: begin
               if (bus.start) begin
                  idx     <= '0;
                  settle  <= SETTLE;
                  pass    <= 1'b1;
                  fail_a  <= '0;
                  fail_b  <= '0;
`ifdef COMP_BIST_ERRCNT_EN
                  err_cnt <= '0;
`endif
                  busy    <= 1'b1;
                  done    <= 1'b0;
                  state   <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (settle <= 4'd1) begin
                  state <= ST_CHECK;
               end else begin
                  settle <= settle - 4'd1;
               end
            end
            ST_CHECK: begin
               if (mismatch) begin
                  if (pass) begin
                     pass   <= 1'b0;
                     fail_a <= idx[IW-1:WIDTH];
                     fail_b <= idx[WIDTH-1:0];
                  end
`ifdef COMP_BIST_ERRCNT_EN
                  if (err_cnt != '1) begin
                     err_cnt <= err_cnt + 1'b1;
                  end
`endif
               end
               if ((idx == '1) || (STOP_ON_FAIL && mismatch)) begin
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  state <= ST_DONE;
               end else begin
                  idx    <= idx + 1'b1;
                  settle <= SETTLE;
                  state  <= ST_WAIT;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_comp_bist_ctrl.sv
// Bench for comp_bist_ctrl: faulty-comparator stub, sweep-level reference model, per-cycle compare.
// Builds with or without COMP_BIST_ERRCNT_EN; expected literals follow the macro.
`timescale 1ns/1ps
module tb_comp_bist_ctrl;

   localparam int W  = 2;
   localparam int NV = 1 << (2 * W);
   localparam int P  = 2;   // SETTLE_CYC + 1 for the main instance

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   mode = 0;          // 0 ideal, 1 eq stuck at 0, 2 gt/lt swapped at a=2,b=1
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   comp_bist_ctrl_if #(.WIDTH(W)) bus ();
   comp_bist_ctrl_if #(.WIDTH(W)) bus3 ();

   comp_bist_ctrl #(.WIDTH(W), .SETTLE_CYC(1)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.master)
   );

   comp_bist_ctrl #(.WIDTH(W), .SETTLE_CYC(3)) dut3 (
      .clk (clk),
      .rst (rst),
      .bus (bus3.master)
   );

   function automatic logic [2:0] ideal(input int a, input int b);
      return {a > b, a < b, a == b};
   endfunction

   function automatic logic [2:0] faulty(input int m, input int a, input int b);
      logic [2:0] r;
      r = ideal(a, b);
      if (m == 1) r[0] = 1'b0;
      if (m == 2 && a == 2 && b == 1) r = {r[1], r[2], r[0]};
      return r;
   endfunction

   always_comb begin
      logic [2:0] r;
      r = faulty(mode, int'(bus.a_out), int'(bus.b_out));
      bus.gt_in = r[2];
      bus.lt_in = r[1];
      bus.eq_in = r[0];
   end

   assign bus3.gt_in = (bus3.a_out > bus3.b_out);
   assign bus3.lt_in = (bus3.a_out < bus3.b_out);
   assign bus3.eq_in = (bus3.a_out == bus3.b_out);

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   // Reference model state: cycles since the accepted start, and sweep outcome.
   bit m_sweep = 1'b0;
   int m_k = 0;
   int m_t = 0;
   int m_end = 0;
   int m_pass = 0;
   int m_fa = 0;
   int m_fb = 0;
   int m_err = 0;

   task automatic model_start();
      int first;
      first = -1;
      m_err = 0;
      for (int v = 0; v < NV; v++) begin
         if (faulty(mode, v >> W, v % (1 << W)) != ideal(v >> W, v % (1 << W))) begin
            m_err++;
            if (first < 0) first = v;
         end
      end
`ifdef COMP_BIST_ERRCNT_EN
      m_end = NV - 1;
`else
      m_end = (first < 0) ? NV - 1 : first;
`endif
      m_t     = (m_end + 1) * P;
      m_pass  = (first < 0) ? 1 : 0;
      m_fa    = (first < 0) ? 0 : first >> W;
      m_fb    = (first < 0) ? 0 : first % (1 << W);
      m_k     = 0;
      m_sweep = 1'b1;
   endtask

   task automatic compare_cycle();
      int vi;
      if (!m_sweep) begin
         chk("idle_a", int'(bus.a_out), 0);
         chk("idle_b", int'(bus.b_out), 0);
         chk("idle_busy", int'(bus.busy), 0);
         chk("idle_done", int'(bus.done), 0);
         chk("idle_pass", int'(bus.pass), 0);
      end else if (m_k < m_t) begin
         vi = m_k / P;
         chk("run_busy", int'(bus.busy), 1);
         chk("run_done", int'(bus.done), 0);
         chk("run_a", int'(bus.a_out), vi >> W);
         chk("run_b", int'(bus.b_out), vi % (1 << W));
      end else begin
         chk("end_busy", int'(bus.busy), 0);
         chk("end_done", int'(bus.done), 1);
         chk("end_pass", int'(bus.pass), m_pass);
         chk("end_fail_a", int'(bus.fail_a), m_fa);
         chk("end_fail_b", int'(bus.fail_b), m_fb);
         chk("end_a", int'(bus.a_out), m_end >> W);
         chk("end_b", int'(bus.b_out), m_end % (1 << W));
`ifdef COMP_BIST_ERRCNT_EN
         chk("end_err_cnt", int'(bus.err_cnt), m_err);
`endif
      end
   endtask

   task automatic pulse_start();
      @(negedge clk);
      bus.start = 1'b1;
      @(posedge clk);
      #1 bus.start = 1'b0;
   endtask

   task automatic wait_done(input int rp1, input int rp2, output int n);
      n = 0;
      while (!bus.done && n < 300) begin
         @(posedge clk);
         #1;
         n++;
         bus.start = (n == rp1 || n == rp2) ? 1'b1 : 1'b0;
      end
      bus.start = 1'b0;
      if (n >= 300) $display("FAIL wait_done: got timeout expected done");
   endtask

   task automatic check_result(input string nm, input int n_exp, input int pass_exp,
                               input int fa_exp, input int fb_exp, input int err_exp);
      int n;
      pulse_start();
      wait_done(-1, -1, n);
      chk({nm, "_cycles"}, n, n_exp);
      chk({nm, "_pass"}, int'(bus.pass), pass_exp);
      chk({nm, "_fail_a"}, int'(bus.fail_a), fa_exp);
      chk({nm, "_fail_b"}, int'(bus.fail_b), fb_exp);
`ifdef COMP_BIST_ERRCNT_EN
      chk({nm, "_err_cnt"}, int'(bus.err_cnt), err_exp);
`else
      if (err_exp < 0) $display("note: negative err_exp");
`endif
   endtask

   initial begin
      int n;
      bus.start  = 1'b0;
      bus3.start = 1'b0;

      fork
         forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
               m_sweep = 1'b0;
            end else if (bus.start && !(m_sweep && m_k < m_t)) begin
               model_start();
            end else if (m_sweep && m_k < m_t) begin
               m_k++;
            end
         end
         forever begin
            @(negedge clk);
            compare_cycle();
         end
      join_none

      repeat (3) @(negedge clk);
      chk("rst_busy", int'(bus.busy), 0);
      chk("rst_done", int'(bus.done), 0);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      mode = 0;
      check_result("ideal", 32, 1, 0, 0, 0);

      mode = 1;
`ifdef COMP_BIST_ERRCNT_EN
      check_result("eq_stuck", 32, 0, 0, 0, 4);
`else
      check_result("eq_stuck", 2, 0, 0, 0, 0);
`endif

      mode = 2;
`ifdef COMP_BIST_ERRCNT_EN
      check_result("swap21", 32, 0, 2, 1, 1);
`else
      check_result("swap21", 20, 0, 2, 1, 0);
`endif

      mode = 0;
      pulse_start();
      repeat (9) @(posedge clk);
      #2 rst = 1'b1;
      #1;
      chk("midrst_a", int'(bus.a_out), 0);
      chk("midrst_b", int'(bus.b_out), 0);
      chk("midrst_busy", int'(bus.busy), 0);
      chk("midrst_done", int'(bus.done), 0);
      chk("midrst_pass", int'(bus.pass), 0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      check_result("after_rst", 32, 1, 0, 0, 0);

      pulse_start();
      wait_done(5, 15, n);
      chk("repulse_cycles", n, 32);
      chk("repulse_pass", int'(bus.pass), 1);

      @(negedge clk);
      bus3.start = 1'b1;
      @(posedge clk);
      #1 bus3.start = 1'b0;
      n = 0;
      while (!bus3.done && n < 300) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk("settle3_cycles", n, 64);
      chk("settle3_pass", int'(bus3.pass), 1);
      chk("settle3_a", int'(bus3.a_out), 3);
      chk("settle3_b", int'(bus3.b_out), 3);

      repeat (3) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
